// File: rtl/ysyx_220066_csr_unit.sv
`default_nettype none
// ============================================================================
// ysyx_220066_csr_unit : machine-mode CSRs, trap entry/exit, timer interrupt
// Revision: 1.0
// ============================================================================
module ysyx_220066_csr_unit #(
  parameter int          XLEN         = 64,
  parameter bit          HAS_COUNTERS = 1'b1,
  parameter logic [63:0] MSTATUS_RST  = 64'ha0001800
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_src,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            exc_valid,
  input  logic [XLEN-1:0] exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic            mret,
  input  logic            instr_retire,
  input  logic            irq_ok,
  input  logic            mtip,
  output logic            trap_jmp,
  output logic [XLEN-1:0] trap_pc,
  output logic            irq_taken
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [XLEN-1:0] MSTATUS_INIT = XLEN'(MSTATUS_RST);
  localparam logic [XLEN-1:0] IRQ_CAUSE    = {1'b1, {(XLEN-5){1'b0}}, 4'd7};
  localparam logic [XLEN-1:0] VEC_OFFSET   = XLEN'(28);
  localparam logic [XLEN-1:0] ONE          = XLEN'(1);

  logic [XLEN-1:0] mstatus;
  logic            mie_mtie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mcycle;
  logic [XLEN-1:0] minstret;

  logic            addr_ok;
  logic [XLEN-1:0] old_val;
  logic [XLEN-1:0] wdata;
  logic            csr_wr;
  logic            irq_pend;
  logic            trap_enter;
  logic [XLEN-1:0] tvec_base;

  // Read mux; mhartid reads as zero and mip is a live view of the timer line.
  always_comb begin
    old_val = '0;
    addr_ok = 1'b1;
    case (csr_addr)
      ADDR_MSTATUS:  old_val = mstatus;
      ADDR_MIE:      old_val[7] = mie_mtie;
      ADDR_MIP:      old_val[7] = mtip;
      ADDR_MTVEC:    old_val = mtvec;
      ADDR_MSCRATCH: old_val = mscratch;
      ADDR_MEPC:     old_val = mepc;
      ADDR_MCAUSE:   old_val = mcause;
      ADDR_MHARTID:  old_val = '0;
      ADDR_MCYCLE:   if (HAS_COUNTERS) old_val = mcycle;   else addr_ok = 1'b0;
      ADDR_MINSTRET: if (HAS_COUNTERS) old_val = minstret; else addr_ok = 1'b0;
      default:       addr_ok = 1'b0;
    endcase
  end

  assign csr_rdata   = old_val;
  assign csr_illegal = (csr_op != OP_NONE) && (!addr_ok || (csr_addr == ADDR_MHARTID));

  always_comb begin
    case (csr_op)
      OP_WRITE: wdata = csr_src;
      OP_SET:   wdata = old_val | csr_src;
      OP_CLEAR: wdata = old_val & ~csr_src;
      default:  wdata = old_val;
    endcase
  end

  assign irq_pend   = mstatus[3] & mie_mtie & mtip;
  assign irq_taken  = irq_pend & irq_ok & !exc_valid & !mret;
  assign trap_enter = exc_valid | irq_taken;
  assign csr_wr     = (csr_op != OP_NONE) && !csr_illegal && !exc_valid && !mret && !irq_taken;

  assign trap_jmp  = exc_valid | mret | irq_taken;
  assign tvec_base = {mtvec[XLEN-1:2], 2'b00};

  always_comb begin
    if (exc_valid)      trap_pc = tvec_base;
    else if (mret)      trap_pc = mepc;
    else if (irq_taken) trap_pc = tvec_base + ((mtvec[1:0] == 2'b01) ? VEC_OFFSET : '0);
    else                trap_pc = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus  <= MSTATUS_INIT;
      mie_mtie <= 1'b0;
      mtvec    <= '0;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
    end else if (trap_enter) begin
      mepc          <= {exc_pc[XLEN-1:1], 1'b0};
      mcause        <= exc_valid ? exc_cause : IRQ_CAUSE;
      mstatus[7]    <= mstatus[3];
      mstatus[3]    <= 1'b0;
      mstatus[12:11] <= 2'b11;
    end else if (mret) begin
      mstatus[3]    <= mstatus[7];
      mstatus[7]    <= 1'b1;
      mstatus[12:11] <= 2'b00;
    end else if (csr_wr) begin
      case (csr_addr)
        ADDR_MSTATUS:  mstatus  <= wdata;
        ADDR_MIE:      mie_mtie <= wdata[7];
        // Reserved modes 10/11 collapse to direct mode.
        ADDR_MTVEC:    mtvec    <= {wdata[XLEN-1:2], wdata[1] ? 2'b00 : wdata[1:0]};
        ADDR_MSCRATCH: mscratch <= wdata;
        ADDR_MEPC:     mepc     <= {wdata[XLEN-1:1], 1'b0};
        ADDR_MCAUSE:   mcause   <= wdata;
        default:       ;
      endcase
    end
  end

  generate
    if (HAS_COUNTERS) begin : g_counters
      always_ff @(posedge clk) begin
        if (rst) begin
          mcycle   <= '0;
          minstret <= '0;
        end else begin
          if (csr_wr && (csr_addr == ADDR_MCYCLE))        mcycle <= wdata;
          else                                            mcycle <= mcycle + ONE;
          if (csr_wr && (csr_addr == ADDR_MINSTRET))      minstret <= wdata;
          else if (instr_retire)                          minstret <= minstret + ONE;
        end
      end
    end else begin : g_no_counters
      assign mcycle   = '0;
      assign minstret = '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ysyx_220066_csr_unit.sv
`default_nettype none
// Bench for ysyx_220066_csr_unit: directed scenarios then random traffic,
// all outputs compared each cycle against an address-indexed CSR model.
module tb_ysyx_220066_csr_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [63:0] csr_src;
  logic [63:0] csr_rdata;
  logic        csr_illegal;
  logic        exc_valid;
  logic [63:0] exc_cause;
  logic [63:0] exc_pc;
  logic        mret;
  logic        instr_retire;
  logic        irq_ok;
  logic        mtip;
  logic        trap_jmp;
  logic [63:0] trap_pc;
  logic        irq_taken;

  int total = 0;
  int bad   = 0;

  // Architectural state keyed by CSR address.
  logic [63:0] m [logic [11:0]];

  always #5 clk = ~clk;

  ysyx_220066_csr_unit dut (
    .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_op(csr_op), .csr_src(csr_src),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .exc_valid(exc_valid),
    .exc_cause(exc_cause), .exc_pc(exc_pc), .mret(mret), .instr_retire(instr_retire),
    .irq_ok(irq_ok), .mtip(mtip), .trap_jmp(trap_jmp), .trap_pc(trap_pc),
    .irq_taken(irq_taken)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_read(input logic [11:0] a);
    if (a == 12'h344) return {56'd0, mtip, 7'd0};
    if (m.exists(a))  return m[a];
    return 64'd0;
  endfunction

  function automatic bit model_legal(input logic [11:0] a);
    return (a == 12'h344) || m.exists(a);
  endfunction

  function automatic bit model_irq();
    logic [63:0] ms = m[12'h300];
    return ms[3] && m[12'h304][7] && mtip && irq_ok && !exc_valid && !mret;
  endfunction

  task automatic model_reset();
    m.delete();
    m[12'h300] = 64'ha0001800;
    m[12'h304] = 0; m[12'h305] = 0; m[12'h340] = 0;
    m[12'h341] = 0; m[12'h342] = 0; m[12'hB00] = 0; m[12'hB02] = 0;
  endtask

  task automatic model_tick();
    logic [63:0] old = model_read(csr_addr);
    logic [63:0] nv;
    logic [63:0] ms = m[12'h300];
    bit irq = model_irq();
    m[12'hB00] = m[12'hB00] + 1;
    if (instr_retire) m[12'hB02] = m[12'hB02] + 1;
    if (exc_valid || irq) begin
      m[12'h341] = exc_pc & ~64'd1;
      m[12'h342] = exc_valid ? exc_cause : 64'h8000000000000007;
      ms[7] = ms[3]; ms[3] = 1'b0; ms[12:11] = 2'b11;
      m[12'h300] = ms;
    end else if (mret) begin
      ms[3] = ms[7]; ms[7] = 1'b1; ms[12:11] = 2'b00;
      m[12'h300] = ms;
    end else if (csr_op != 2'b00 && model_legal(csr_addr)) begin
      nv = (csr_op == 2'b01) ? csr_src : (csr_op == 2'b10) ? (old | csr_src) : (old & ~csr_src);
      case (csr_addr)
        12'h304: m[csr_addr] = nv & 64'h80;
        12'h305: m[csr_addr] = nv[1] ? (nv & ~64'd3) : nv;
        12'h341: m[csr_addr] = nv & ~64'd1;
        12'h344: ;
        default: m[csr_addr] = nv;
      endcase
    end
  endtask

  // Compare all outputs against the model, then clock the cycle.
  task automatic cycle();
    logic [63:0] base, epc;
    bit e_irq, e_ill;
    #1;
    e_irq = model_irq();
    e_ill = (csr_op != 2'b00) && (!model_legal(csr_addr) || csr_addr == 12'hF14);
    base  = m[12'h305] & ~64'd3;
    chk("rdata", csr_rdata, model_read(csr_addr));
    chk("illegal", {63'd0, csr_illegal}, {63'd0, e_ill});
    chk("irq_taken", {63'd0, irq_taken}, {63'd0, e_irq});
    chk("trap_jmp", {63'd0, trap_jmp}, {63'd0, exc_valid | mret | e_irq});
    if (exc_valid || mret || e_irq) begin
      epc = exc_valid ? base : mret ? m[12'h341] :
            base + ((m[12'h305][1:0] == 2'b01) ? 64'd28 : 64'd0);
      chk("trap_pc", trap_pc, epc);
    end
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csr_op = 2'b00; csr_src = 0; exc_valid = 0; exc_cause = 0; exc_pc = 0;
    mret = 0; instr_retire = 0; irq_ok = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic csr_access(input logic [11:0] a, input logic [1:0] op, input logic [63:0] s);
    idle(); csr_addr = a; csr_op = op; csr_src = s;
    cycle();
  endtask

  task automatic read_const(input string tag, input logic [11:0] a, input logic [63:0] exp);
    idle(); csr_addr = a;
    #1;
    chk(tag, csr_rdata, exp);
    cycle();
  endtask

  logic [11:0] alist [10] = '{12'h300, 12'h304, 12'h344, 12'h305, 12'h340,
                              12'h341, 12'h342, 12'hF14, 12'hB00, 12'hB02};

  initial begin
    mtip = 0; csr_addr = 12'h300; idle();
    do_reset();

    read_const("mstatus_rst", 12'h300, 64'ha0001800);
    idle(); csr_addr = 12'h123; csr_op = 2'b01; csr_src = 64'hff;
    #1; chk("illegal_123", {63'd0, csr_illegal}, 64'd1);
    cycle();

    csr_access(12'h305, 2'b10, 64'd1);
    read_const("mtvec_set", 12'h305, 64'd1);
    csr_access(12'h305, 2'b11, 64'd1);
    read_const("mtvec_clr", 12'h305, 64'd0);
    csr_access(12'h305, 2'b01, 64'd3);
    read_const("mtvec_mode3", 12'h305, 64'd0);

    idle(); csr_addr = 12'hF14;
    #1; chk("mhartid_rd_legal", {63'd0, csr_illegal}, 64'd0);
    cycle();
    idle(); csr_addr = 12'hF14; csr_op = 2'b01;
    #1; chk("mhartid_wr_illegal", {63'd0, csr_illegal}, 64'd1);
    cycle();

    csr_access(12'h341, 2'b01, 64'h1235);
    read_const("mepc_bit0", 12'h341, 64'h1234);

    // Synchronous exception with a competing CSR write.
    csr_access(12'h305, 2'b01, 64'h80001000);
    csr_access(12'h300, 2'b10, 64'h8);
    idle(); exc_valid = 1; exc_cause = 64'd11; exc_pc = 64'h80000010;
    csr_addr = 12'h340; csr_op = 2'b01; csr_src = 64'h55;
    #1; chk("exc_pc_out", trap_pc, 64'h80001000);
    cycle();
    read_const("exc_mepc", 12'h341, 64'h80000010);
    read_const("exc_mstatus", 12'h300, 64'ha0001880);
    read_const("exc_drop_wr", 12'h340, 64'd0);

    idle(); mret = 1;
    #1; chk("mret_pc", trap_pc, 64'h80000010);
    cycle();
    read_const("mret_mstatus", 12'h300, 64'ha0000088);

    // Vectored timer interrupt.
    csr_access(12'h305, 2'b01, 64'h80001001);
    csr_access(12'h304, 2'b01, 64'hffff);
    read_const("mie_bit7", 12'h304, 64'h80);
    mtip = 1;
    idle(); exc_pc = 64'h80000200;
    #1; chk("irq_blocked", {63'd0, irq_taken}, 64'd0);
    cycle();
    idle(); irq_ok = 1; exc_pc = 64'h80000200;
    #1; chk("irq_pc", trap_pc, 64'h8000101C);
    cycle();
    read_const("irq_mcause", 12'h342, 64'h8000000000000007);
    read_const("irq_mepc", 12'h341, 64'h80000200);
    read_const("mip_view", 12'h344, 64'h80);
    mtip = 0;

    idle(); exc_valid = 1; mret = 1; exc_cause = 64'd2; exc_pc = 64'h80000300;
    #1; chk("exc_over_mret", trap_pc, 64'h80001000);
    cycle();
    read_const("exc_over_mret_cause", 12'h342, 64'd2);

    csr_access(12'hB00, 2'b01, '1);
    read_const("mcycle_ones", 12'hB00, '1);
    read_const("mcycle_wrap", 12'hB00, 64'd0);

    do_reset();
    for (int i = 0; i < 10; i++) begin
      idle(); csr_addr = 12'h340; instr_retire = (i % 2 == 1);
      cycle();
    end
    read_const("minstret5", 12'hB02, 64'd5);

    for (int i = 0; i < 600; i++) begin
      int k;
      idle();
      k = $urandom_range(0, 10);
      csr_addr = (k == 10) ? 12'($urandom) : alist[k];
      csr_op   = 2'($urandom_range(0, 3));
      csr_src  = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) csr_src = 64'h88;
      exc_valid    = ($urandom_range(0, 15) == 0);
      mret         = ($urandom_range(0, 15) == 0);
      exc_cause    = {$urandom, $urandom};
      exc_pc       = {$urandom, $urandom};
      instr_retire = 1'($urandom);
      irq_ok       = 1'($urandom);
      mtip         = 1'($urandom);
      if ($urandom_range(0, 199) == 0) do_reset();
      else cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
